apb_slave_mem_responder: RTL and testbench

- Synthesizable APB4 completer: the responder end of the APB interface that the master agent drives.
- Fronts a byte-lane-writable word memory with programmable wait states and PSLVERR generation.
- Serves as the RTL slave model in the SPI master IP bench, and as a reference target for the APB master agent and scoreboard.

---
 rtl/apb_slave_mem_responder.sv | 152 +++++++++++++++
 tb/tb_apb_slave_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem_responder.sv
// APB4 completer in front of a byte-lane-writable word memory.
// Programmable wait states, address/protection error responses and a saturating error counter.
module apb_slave_mem_responder #(
    parameter int                         ADDRESS_WIDTH = 12,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   MIN_ADDRESS   = 12'h000,
    parameter logic [ADDRESS_WIDTH-1:0]   MAX_ADDRESS   = 12'h0FF,
    parameter bit                         SECURE_ONLY   = 1'b0
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    input  logic [3:0]                wait_cfg,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr,
    output logic                      xfer_done,
    output logic [7:0]                err_count
);

    localparam int DEPTH  = (int'(MAX_ADDRESS) - int'(MIN_ADDRESS) + 1) / 4;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q;
    logic                       write_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [STRB_W-1:0]          strb_q;
    logic                       err_q;

    logic [DATA_WIDTH-1:0]      mem [DEPTH];

    logic                       below, above, setup_err;
    logic                       in_setup, complete;
    logic                       cur_write, cur_err;
    logic [ADDRESS_WIDTH-1:0]   cur_addr, cur_off;
    logic [DATA_WIDTH-1:0]      cur_wdata;
    logic [STRB_W-1:0]          cur_strb;
    logic [IDX_W-1:0]           idx;
    logic                       unused_bits;

    // Range checks collapse to constants when a bound sits at the edge of the address space.
    if (MIN_ADDRESS == '0) begin : g_no_low
        assign below = 1'b0;
    end else begin : g_low
        assign below = (paddr < MIN_ADDRESS);
    end

    if (MAX_ADDRESS == '1) begin : g_no_high
        assign above = 1'b0;
    end else begin : g_high
        assign above = (paddr > MAX_ADDRESS);
    end

    assign setup_err = below | above | (paddr[1:0] != 2'b00) | (SECURE_ONLY && pprot[1]);

    // A zero-wait transfer completes on the SETUP edge, before anything is latched,
    // so the completion path takes the live bus in SETUP and the latched copy in ACCESS.
    assign in_setup  = (state_q == SETUP);
    assign cur_write = in_setup ? pwrite    : write_q;
    assign cur_addr  = in_setup ? paddr     : addr_q;
    assign cur_wdata = in_setup ? pwdata    : wdata_q;
    assign cur_strb  = in_setup ? pstrb     : strb_q;
    assign cur_err   = in_setup ? setup_err : err_q;
    assign cur_off   = cur_addr - MIN_ADDRESS;
    assign idx       = cur_off[IDX_W+1:2];

    assign unused_bits = &{1'b0, pprot[2], pprot[0], cur_off[ADDRESS_WIDTH-1:IDX_W+2], cur_off[1:0]};

    // pready is the completion handshake: the transfer finishes in the cycle it is high,
    // with pslverr and prdata qualified by it; all three drop the following cycle.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) state_d = SETUP;
            end
            SETUP: begin
                state_d  = ACCESS;
                complete = (wait_cfg == 4'd0);
            end
            ACCESS: begin
                if (pready) begin
                    state_d = IDLE;
                end else if (!(psel && penable)) begin
                    state_d = IDLE;
                end else begin
                    complete = (cnt_q == 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            xfer_done <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state_q   <= state_d;
            pready    <= complete;
            pslverr   <= complete && cur_err;
            prdata    <= (complete && !cur_write && !cur_err) ? mem[idx] : '0;
            xfer_done <= pready;
            if (complete && cur_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            if (in_setup) begin
                write_q <= pwrite;
                addr_q  <= paddr;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                err_q   <= setup_err;
                cnt_q   <= wait_cfg;
            end else if (state_d == IDLE) begin
                cnt_q <= 4'd0;
            end else if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Reset holds the FSM in IDLE, so complete cannot fire and no pending write lands.
    always_ff @(posedge pclk) begin
        if (complete && cur_write && !cur_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (cur_strb[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// Directed bench for apb_slave_mem_responder: two instances (default and secure-only) share one bus;
// a driver queues expected completions and a negedge monitor checks them.
module tb_apb_slave_mem_responder;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  wait_cfg;

    logic        pready_a, pslverr_a, xfer_done_a;
    logic [31:0] prdata_a;
    logic [7:0]  err_count_a;
    logic        pready_b, pslverr_b, xfer_done_b;
    logic [31:0] prdata_b;
    logic [7:0]  err_count_b;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        logic        err_a;
        logic        err_b;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int lat_cnt = 0;
    int done_seen = 0;
    int done_exp = 0;
    logic expect_done_a = 1'b0;
    logic expect_done_b = 1'b0;

    apb_slave_mem_responder dut_a (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .wait_cfg(wait_cfg),
        .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a),
        .xfer_done(xfer_done_a), .err_count(err_count_a)
    );

    apb_slave_mem_responder #(.SECURE_ONLY(1'b1)) dut_b (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .wait_cfg(wait_cfg),
        .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b),
        .xfer_done(xfer_done_b), .err_count(err_count_b)
    );

    // ---------------- clock / watchdog ----------------
    always #5 pclk = ~pclk;

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required finish within 300000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge pclk) begin
        if (preset) begin
            lat_cnt       = 0;
            expect_done_a = 1'b0;
            expect_done_b = 1'b0;
        end else begin
            check("quiet_outputs",
                  32'({xfer_done_a, xfer_done_b, pslverr_a & ~pready_a, pslverr_b & ~pready_b,
                       (|prdata_a) & ~pready_a}),
                  32'({expect_done_a, expect_done_b, 3'b000}));
            if (xfer_done_a) done_seen++;
            if (pready_a || pready_b) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pready: got pready_a=%b pready_b=%b, required none (t=%0t)",
                             pready_a, pready_b, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pready_pair", 32'({pready_a, pready_b}), 32'(2'b11));
                    check("latency", lat_cnt, mon_e.lat);
                    check("pslverr_a", 32'(pslverr_a), 32'(mon_e.err_a));
                    check("pslverr_b", 32'(pslverr_b), 32'(mon_e.err_b));
                    if (mon_e.is_read) check("prdata_a", prdata_a, mon_e.rdata);
                end
                lat_cnt = 0;
            end else if (psel && penable) begin
                lat_cnt++;
            end else begin
                lat_cnt = 0;
            end
            expect_done_a = pready_a;
            expect_done_b = pready_b;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] wt,
                            input logic [31:0] exp_rd, input logic ea, input logic eb);
        exp_t e;
        int tmo;
        e.is_read = !wr;
        e.rdata   = exp_rd;
        e.err_a   = ea;
        e.err_b   = eb;
        e.lat     = int'(wt) + 1;
        exp_q.push_back(e);
        done_exp++;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; pprot = prot; wait_cfg = wt;
        @(posedge pclk); #1;
        penable = 1'b1;
        tmo = 0;
        forever begin
            @(negedge pclk);
            if (pready_a) break;
            tmo++;
            if (tmo > 40) begin
                n_cmp++;
                n_err++;
                $display("FAIL pready_timeout: got no pready in 40 cycles, required pready for addr %h", addr);
                break;
            end
            // Once the responder has latched the transfer, the held bus fields must not matter.
            if (tmo >= 2) begin
                paddr  = 12'($urandom);
                pwdata = $urandom;
                pwrite = ~wr;
            end
        end
    endtask

    task automatic apb_idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        preset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; wait_cfg = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_pready",    32'({pready_a, pready_b}), 32'd0);
        check("rst_pslverr",   32'({pslverr_a, pslverr_b}), 32'd0);
        check("rst_xfer_done", 32'({xfer_done_a, xfer_done_b}), 32'd0);
        check("rst_prdata",    prdata_a | prdata_b, 32'd0);
        check("rst_err_count", 32'({err_count_a, err_count_b}), 32'd0);
        @(posedge pclk); #1;
        preset = 1'b0;
        apb_idle(2);

        // basic write/read, zero wait
        apb_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0, 32'h0, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 3'b000, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        apb_idle(1);

        // byte lanes
        apb_xfer(1'b1, 12'h020, 32'hAABBCCDD, 4'hF, 3'b000, 4'd1, 32'h0, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b1, 12'h020, 32'h11223344, 4'b0101, 3'b000, 4'd2, 32'h0, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b0, 12'h020, 32'h0, 4'h0, 3'b000, 4'd0, 32'hAA22CC44, 1'b0, 1'b0);
        apb_idle(1);

        // wait states on a read
        apb_xfer(1'b0, 12'h010, 32'h0, 4'hF, 3'b000, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0);
        apb_idle(2);

        // address errors: out of range aliases word 0x000, misaligned aliases word 0x010
        apb_xfer(1'b1, 12'h000, 32'h0BADF00D, 4'hF, 3'b000, 4'd0, 32'h0, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b1, 12'h100, 32'hFFFFFFFF, 4'hF, 3'b000, 4'd0, 32'h0, 1'b1, 1'b1);
        apb_idle(1);
        apb_xfer(1'b1, 12'h013, 32'h01010101, 4'hF, 3'b000, 4'd1, 32'h0, 1'b1, 1'b1);
        apb_idle(3);
        check("err_count_a_2", 32'(err_count_a), 32'd2);
        check("err_count_b_2", 32'(err_count_b), 32'd2);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 3'b000, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, 3'b000, 4'd0, 32'h0BADF00D, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b0, 12'h100, 32'h0, 4'h0, 3'b000, 4'd2, 32'h0, 1'b1, 1'b1);
        apb_idle(1);
        apb_xfer(1'b1, 12'h0FC, 32'h600DCAFE, 4'hF, 3'b000, 4'd0, 32'h0, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b0, 12'h0FC, 32'h0, 4'h0, 3'b000, 4'd1, 32'h600DCAFE, 1'b0, 1'b0);
        apb_idle(1);

        // nonsecure accesses: only the secure-only instance errors
        apb_xfer(1'b1, 12'h040, 32'h5555AAAA, 4'hF, 3'b010, 4'd0, 32'h0, 1'b0, 1'b1);
        apb_idle(1);
        apb_xfer(1'b0, 12'h040, 32'h0, 4'h0, 3'b000, 4'd0, 32'h5555AAAA, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b0, 12'h040, 32'h0, 4'h0, 3'b010, 4'd1, 32'h5555AAAA, 1'b0, 1'b1);
        apb_idle(3);
        check("err_count_a_3", 32'(err_count_a), 32'd3);
        check("err_count_b_5", 32'(err_count_b), 32'd5);

        // back-to-back with psel held high
        apb_xfer(1'b1, 12'h004, 32'hCAFEF00D, 4'hF, 3'b000, 4'd0, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 3'b000, 4'd0, 32'hCAFEF00D, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h008, 32'h76543210, 4'hF, 3'b000, 4'd2, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b000, 4'd1, 32'h76543210, 1'b0, 1'b0);
        apb_idle(1);

        // preload words that the aborted transfers target
        apb_xfer(1'b1, 12'h030, 32'h12345678, 4'hF, 3'b000, 4'd0, 32'h0, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b1, 12'h034, 32'h9ABCDEF0, 4'hF, 3'b000, 4'd0, 32'h0, 1'b0, 1'b0);
        apb_idle(3);
        check("xfer_done_count", done_seen, done_exp);

        // protocol abort: penable falls after two ACCESS cycles of a 5-wait write
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b000; wait_cfg = 4'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
        apb_idle(4);
        check("abort_err_count", 32'(err_count_a), 32'd3);

        // reset in the middle of another 5-wait write
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h034;
        pwdata = 32'h00000000; pstrb = 4'hF; pprot = 3'b000; wait_cfg = 4'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("midrst_outputs",
              32'({pready_a, pslverr_a, xfer_done_a, pready_b, pslverr_b, xfer_done_b}), 32'd0);
        check("midrst_prdata", prdata_a, 32'd0);
        check("midrst_err_count", 32'({err_count_a, err_count_b}), 32'd0);
        @(posedge pclk); #1;
        preset = 1'b0;
        apb_idle(3);
        check("abort_no_xfer_done", done_seen, done_exp);

        apb_xfer(1'b0, 12'h030, 32'h0, 4'h0, 3'b000, 4'd0, 32'h12345678, 1'b0, 1'b0);
        apb_idle(1);
        apb_xfer(1'b0, 12'h034, 32'h0, 4'h0, 3'b000, 4'd4, 32'h9ABCDEF0, 1'b0, 1'b0);
        apb_idle(3);
        check("final_xfer_done_count", done_seen, done_exp);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
